// File: rtl/serial_add_sequencer.sv
// Feeds two parallel operands LSB-first into a bit-serial adder and collects the registered
// sum bits and final carry into a parallel result held under a valid/ready output handshake.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_cin,
  output logic             ser_start,
  input  logic             ser_sum,
  input  logic             ser_cout,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_nxt;
  logic             r_cin_q;
  logic             r_cout;
  logic             w_last;
  logic             w_first;

  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_first = (r_cnt == '0);

  // The adder's sum is one cycle behind the bit driven, so captures enter at the MSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_nxt = ser_sum;
    end else begin : g_res_wn
      assign w_res_nxt = {ser_sum, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last)    w_state_nxt = DRAIN;
      DRAIN:                  w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_cin_q <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= in_a;
            r_b_sh  <= in_b;
            r_cin_q <= in_cin;
            r_cnt   <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
          end
        end
        SHIFT: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (!w_first) r_res <= w_res_nxt;
        end
        DRAIN: begin
          r_res  <= w_res_nxt;
          r_cout <= ser_cout;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    ser_a     = 1'b0;
    ser_b     = 1'b0;
    ser_cin   = 1'b0;
    ser_start = 1'b0;
    case (r_state)
      IDLE:  in_ready = 1'b1;
      SHIFT: begin
        busy      = 1'b1;
        ser_a     = r_a_sh[0];
        ser_b     = r_b_sh[0];
        ser_cin   = r_cin_q;
        ser_start = w_first;
      end
      DRAIN: busy      = 1'b1;
      DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_sum  = r_res;
  assign out_cout = r_cout;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: WIDTH=8 and WIDTH=1 instances, each wired to a behavioural serial adder.
module tb_serial_add_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=8 instance
  logic       in_valid, in_ready, in_cin;
  logic [7:0] in_a, in_b, out_sum;
  logic       ser_a, ser_b, ser_cin, ser_start, ser_sum, ser_cout;
  logic       busy, out_valid, out_ready, out_cout;

  // WIDTH=1 instance
  logic       w1_in_valid, w1_in_ready, w1_in_cin;
  logic [0:0] w1_in_a, w1_in_b, w1_out_sum;
  logic       w1_ser_a, w1_ser_b, w1_ser_cin, w1_ser_start, w1_ser_sum, w1_ser_cout;
  logic       w1_busy, w1_out_valid, w1_out_ready, w1_out_cout;

  serial_add_sequencer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .ser_a(ser_a), .ser_b(ser_b), .ser_cin(ser_cin), .ser_start(ser_start),
    .ser_sum(ser_sum), .ser_cout(ser_cout), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
  );

  serial_add_sequencer #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_a(w1_in_a), .in_b(w1_in_b), .in_cin(w1_in_cin),
    .ser_a(w1_ser_a), .ser_b(w1_ser_b), .ser_cin(w1_ser_cin), .ser_start(w1_ser_start),
    .ser_sum(w1_ser_sum), .ser_cout(w1_ser_cout), .busy(w1_busy),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_sum(w1_out_sum), .out_cout(w1_out_cout)
  );

  // Behavioural serial adders: inputs sampled at the edge, sum/carry registered for the next cycle.
  logic m8_carry, m1_carry;
  always @(posedge clk or posedge rst) begin
    logic       c;
    logic [1:0] s;
    if (rst) begin
      ser_sum <= 1'b0; ser_cout <= 1'b0; m8_carry <= 1'b0;
    end else begin
      c = ser_start ? ser_cin : m8_carry;
      s = 2'(ser_a) + 2'(ser_b) + 2'(c);
      ser_sum <= s[0]; ser_cout <= s[1]; m8_carry <= s[1];
    end
  end

  always @(posedge clk or posedge rst) begin
    logic       c;
    logic [1:0] s;
    if (rst) begin
      w1_ser_sum <= 1'b0; w1_ser_cout <= 1'b0; m1_carry <= 1'b0;
    end else begin
      c = w1_ser_start ? w1_ser_cin : m1_carry;
      s = 2'(w1_ser_a) + 2'(w1_ser_b) + 2'(c);
      w1_ser_sum <= s[0]; w1_ser_cout <= s[1]; m1_carry <= s[1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation; result is held for 'hold' cycles with out_ready low before release.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input int hold, input string tag);
    logic [8:0] exp;
    int         n, starts;
    logic       cin_seen;
    exp = 9'(a) + 9'(b) + 9'(cin);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
    starts = 0; cin_seen = 1'b0; n = 0;
    if (ser_start) begin starts++; cin_seen = ser_cin; end
    while (!out_valid && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ser_start) begin starts++; cin_seen = ser_cin; end
    end
    chk({tag, "_lat"},    32'(n),        32'd9);
    chk({tag, "_starts"}, 32'(starts),   32'd1);
    chk({tag, "_sercin"}, 32'(cin_seen), 32'(cin));
    chk({tag, "_sum"},    32'(out_sum),  32'(exp[7:0]));
    chk({tag, "_cout"},   32'(out_cout), 32'(exp[8]));
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel"}, {30'd0, out_valid, in_ready}, 32'b01);
    chk({tag, "_keep"}, {23'd0, out_cout, out_sum}, 32'(exp));
  endtask

  task automatic run1(input logic a, input logic b, input logic cin, input string tag);
    logic [1:0] exp;
    int         n;
    exp = 2'(a) + 2'(b) + 2'(cin);
    @(negedge clk);
    w1_in_valid = 1'b1; w1_in_a = a; w1_in_b = b; w1_in_cin = cin;
    @(posedge clk);
    @(negedge clk);
    w1_in_valid = 1'b0;
    chk({tag, "_start"}, {30'd0, w1_ser_start, w1_ser_cin}, {30'd0, 1'b1, cin});
    n = 0;
    while (!w1_out_valid && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_res"}, {30'd0, w1_out_cout, w1_out_sum}, 32'(exp));
    w1_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w1_out_ready = 1'b0;
    chk({tag, "_rel"}, {30'd0, w1_out_valid, w1_in_ready}, 32'b01);
  endtask

  function automatic logic [31:0] idle_vec();
    return {16'd0, in_ready, busy, out_valid, ser_a, ser_b, ser_start, ser_cin, out_cout, out_sum};
  endfunction

  initial begin
    logic [7:0] hs;
    logic       hc, stable;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
    w1_in_valid = 0; w1_in_a = 0; w1_in_b = 0; w1_in_cin = 0; w1_out_ready = 0;

    #1;
    chk("reset_state", idle_vec(), 32'h8000);
    chk("reset_w1", {29'd0, w1_in_ready, w1_out_valid, w1_busy}, 32'b100);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run8(8'h5A, 8'h33, 1'b0, 0, "d5a33");
    run8(8'hFF, 8'h01, 1'b0, 1, "ripple");
    run8(8'hFF, 8'hFF, 1'b1, 0, "allones");

    // Backpressure in DONE, with an ignored request arriving meanwhile.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h0F; in_cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    hs = out_sum; hc = out_cout; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_valid = 1'b1; in_a = 8'h11; in_b = 8'h11; end
      @(negedge clk);
      in_valid = 1'b0;
      if (!out_valid || in_ready || busy || out_sum !== hs || out_cout !== hc) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_value", {23'd0, hc, hs}, 32'h04C);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", {29'd0, in_ready, out_valid, busy}, 32'b100);

    // Reset in the third SHIFT cycle.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_reset", idle_vec(), 32'h8000);
    @(negedge clk);
    rst = 1'b0;
    run8(8'h01, 8'h02, 1'b1, 0, "after_rst");

    // Reset and request together: nothing accepted.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_a = 8'h77; in_b = 8'h77;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_vs_valid", idle_vec(), 32'h8000);

    for (int i = 0; i < 30; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));

    run1(1'b1, 1'b1, 1'b1, "w1_111");
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run1(v[2], v[1], v[0], $sformatf("w1_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Control stage that wraps a bit-serial adder cell. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake, then streams the operand bits LSB-first into the serial adder. It collects the returned serial sum bits and the final carry into a parallel result, which it presents on a valid/ready output. It sits both upstream of the adder, as parallel-to-serial feeder, and downstream of it, as serial-to-parallel collector.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 1.

Ports:
- clk, input, 1, clock; all state changes on posedge.
- rst, input, 1, reset; asynchronous, active-high.
- in_valid, input, 1, operand request.
- in_ready, output, 1, sequencer can accept operands; equals (state==IDLE).
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- in_cin, input, 1, carry-in.
- ser_a, output, 1, current A bit to the adder.
- ser_b, output, 1, current B bit to the adder.
- ser_cin, output, 1, latched carry-in; meaningful only while ser_start is high.
- ser_start, output, 1, high during bit 0 only; the adder loads its carry from ser_cin.
- ser_sum, input, 1, adder registered sum bit.
- ser_cout, input, 1, adder registered carry-out.
- busy, output, 1, high in SHIFT or DRAIN.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- out_sum, output, WIDTH, collected sum.
- out_cout, output, 1, final carry-out.

Behaviour:
- Adder contract: bit k driven on ser_a/ser_b during cycle c is sampled by the adder at the end of c. Its sum and carry are valid on ser_sum/ser_cout throughout cycle c+1.
- Reset (async) forces the following; no adder transaction is left pending, and in_ready=1 once state is IDLE:
  - state=IDLE, bit counter=0.
  - A/B shift registers, result register, out_cout and latched cin all 0.
  - out_valid=0, busy=0, ser_a=ser_b=ser_start=ser_cin=0.
- IDLE:
  - in_ready=1.
  - On posedge with in_valid=1: load A_sh=in_a, B_sh=in_b, cin_q=in_cin, cnt=0, clear result; go to SHIFT.
- SHIFT (WIDTH cycles):
  - ser_a=A_sh[0], ser_b=B_sh[0], ser_cin=cin_q, ser_start=(cnt==0).
  - Each posedge: shift A_sh and B_sh right, cnt+1.
  - From the second SHIFT cycle onward, each posedge shifts ser_sum into result MSB (shift right).
  - Posedge with cnt==WIDTH-1 goes to DRAIN.
- DRAIN (1 cycle):
  - ser_a/ser_b/ser_start driven 0.
  - Posedge captures the last ser_sum into result MSB and ser_cout into out_cout; go to DONE.
  - After this, result holds exactly WIDTH captures with bit 0 in the LSB.
- DONE:
  - out_valid=1; out_sum and out_cout held stable.
  - On posedge with out_ready=1: go to IDLE. out_valid drops next cycle; out_sum/out_cout keep their value until the next load.
- Ser_* outputs are 0 outside SHIFT except ser_cin, which is don't-care when ser_start=0.
- in_valid is ignored outside IDLE; operands are not buffered.
- out_ready is ignored outside DONE.
- Latency: out_valid rises after posedge number WIDTH+1 following the accepting edge.
- Throughput: one operation per WIDTH+3 cycles at best, since DONE plus IDLE each take at least one cycle.
- WIDTH=1: exactly one SHIFT cycle (ser_start high), then DRAIN.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin modulo 2^(WIDTH+1). There is no separate overflow flag.
- Reset mid-operation (SHIFT, DRAIN or DONE): immediate abort to reset values; the partial result is discarded; the next accepted operation is unaffected.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.

Test Plan:
- WIDTH=8 with a behavioural adder model honouring the contract above.
  - a=0x5A, b=0x33, cin=0 -> out_sum=0x8D, out_cout=0; out_valid rises after the 9th posedge following acceptance; ser_start high exactly one cycle.
- a=0xFF, b=0x01, cin=0 -> out_sum=0x00, out_cout=1 (full carry ripple).
- a=0xFF, b=0xFF, cin=1 -> out_sum=0xFF, out_cout=1; ser_cin=1 while ser_start=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1; out_sum/out_cout stable; in_ready=0. A pulse on in_valid with a=0x11 is not accepted. Release out_ready -> IDLE next cycle.
- Reset mid-SHIFT:
  - Start a=0xAA, b=0x55, then assert rst during SHIFT cycle 3 -> all outputs 0 and in_ready=1 immediately after reset.
  - Then a=0x01, b=0x02, cin=1 -> out_sum=0x04, out_cout=0.
- WIDTH=1 instance: a=1, b=1, cin=1 -> out_sum=1, out_cout=1; out_valid rises after the 2nd posedge following acceptance.
